// File: rtl/div32_issue_ctrl.sv
// Issue/retire wrapper around a fixed-latency unsigned 32-bit pipelined divider.
// Handles signed operands and divide-by-zero, limits issue by credit, and returns results in order from a FIFO.
module div32_issue_ctrl #(
  parameter int unsigned LATENCY    = 32,
  parameter int unsigned FIFO_DEPTH = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  input  logic        in_signed,
  output logic [31:0] div_dataa,
  output logic [31:0] div_datab,
  input  logic [31:0] div_quotient,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quotient,
  output logic        out_dbz
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic valid;
    logic neg;
    logic dbz;
  } tag_t;

  typedef struct packed {
    logic        dbz;
    logic [31:0] quotient;
  } res_t;

  logic          sign_a, sign_b;
  logic [31:0]   mag_a, mag_b;
  logic          accept, push, pop;
  tag_t          new_tag, ret_tag;
  res_t          push_data, head;
  tag_t          tag_q [LATENCY+1];
  res_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] inflight, fifo_count, inflight_nxt, fifo_count_nxt;
  logic [SW-1:0] credit_used;

  // Operand conditioning, retire formatting and next-state bookkeeping.
  always_comb begin
    sign_a = in_signed & in_dividend[31];
    sign_b = in_signed & in_divisor[31];
    mag_a  = sign_a ? 32'(~in_dividend + 32'd1) : in_dividend;
    mag_b  = sign_b ? 32'(~in_divisor + 32'd1) : in_divisor;
    accept = in_valid & in_ready;

    new_tag.valid = accept;
    new_tag.neg   = sign_a ^ sign_b;
    new_tag.dbz   = (in_divisor == 32'd0);

    // tag_q[LATENCY] lines up with the quotient the divider presents this cycle
    ret_tag        = tag_q[LATENCY];
    push           = ret_tag.valid;
    pop            = out_valid & out_ready;
    push_data.dbz  = ret_tag.dbz;
    if (ret_tag.dbz) begin
      push_data.quotient = 32'hFFFF_FFFF;
    end else if (ret_tag.neg) begin
      push_data.quotient = 32'(~div_quotient + 32'd1);
    end else begin
      push_data.quotient = div_quotient;
    end

    inflight_nxt   = inflight + CW'(accept) - CW'(push);
    fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);

    wr_ptr_nxt = wr_ptr;
    if (push) begin
      wr_ptr_nxt = (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    end
    rd_ptr_nxt = rd_ptr;
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end

    // Next head bypasses the array only when the pushed entry becomes the head
    head        = (push && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
    credit_used = SW'(inflight_nxt) + SW'(fifo_count_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready     <= 1'b0;
      div_dataa    <= '0;
      div_datab    <= '0;
      for (int i = 0; i <= int'(LATENCY); i++) tag_q[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= '0;
      fifo_count   <= '0;
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_dbz      <= 1'b0;
    end else begin
      in_ready <= (credit_used < SW'(FIFO_DEPTH));
      if (accept) begin
        div_dataa <= mag_a;
        div_datab <= mag_b;
      end
      tag_q[0] <= new_tag;
      for (int i = 1; i <= int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      inflight   <= inflight_nxt;
      fifo_count <= fifo_count_nxt;
      out_valid  <= (fifo_count_nxt != '0);
      if (fifo_count_nxt != '0) begin
        out_quotient <= head.quotient;
        out_dbz      <= head.dbz;
      end
    end
  end

  // Result storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Credit must make a push into a full FIFO unreachable.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (fifo_count == CW'(FIFO_DEPTH)) && !pop));
  end

endmodule
